multdiv_unit: RTL and testbench

//  Multi-cycle signed 32-bit multiplier/divider; the responder to the mult/div start pulses the decode control emits.

---
 rtl/multdiv_pkg.sv | 23 ++
 rtl/mult_div_step.sv | 36 +++
 rtl/multdiv_unit.sv | 116 +++++++++++
 tb/tb_multdiv_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multi-cycle signed multiplier/divider.
// Used by the iteration step and by the top-level FSM.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  // Unsigned magnitude of a two's-complement word; INT_MIN maps to 2^31, which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_div_step.sv
// One combinational iteration shared by multiply (shift-add) and divide (restoring).
// hi/lo form the accumulator for MUL and the partial remainder / dividend-quotient pair for DIV.
module mult_div_step
  import multdiv_pkg::*;
(
  input  logic             div_mode,
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           fits;

  // NOTE: every signal written here is assigned on every path, so no latch can be inferred.
  always_comb begin
    sum    = hi + ({1'b0, operand} & {(WIDTH+1){lo[0]}});
    rem_sh = {hi[WIDTH-1:0], lo[WIDTH-1]};
    trial  = rem_sh - {1'b0, operand};
    fits   = (rem_sh >= {1'b0, operand});

    if (div_mode) begin
      hi_next = fits ? trial : rem_sh;
      lo_next = {lo[WIDTH-2:0], fits};
    end else begin
      // Carry out of the add shifts into the top of the accumulator.
      hi_next = {1'b0, sum[WIDTH:1]};
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed 32-bit multiplier/divider with fixed 33-edge latency.
// Works on magnitudes and applies the result sign and overflow check in the DONE state.
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH:0]     hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   operand;
  logic               neg;
  logic               div_zero;
  logic               is_div;

  logic [WIDTH:0]     hi_next;
  logic [WIDTH-1:0]   lo_next;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   fin_result;
  logic               fin_exc;
  logic               start;

  assign start = ctrl_MULT | ctrl_DIV;

  mult_div_step u_step (
    .div_mode (state == DIV),
    .hi       (hi),
    .lo       (lo),
    .operand  (operand),
    .hi_next  (hi_next),
    .lo_next  (lo_next)
  );

  always_comb begin
    prod_mag   = {hi[WIDTH-1:0], lo};
    prod       = neg ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;
    quot       = neg ? (~lo + WIDTH'(1)) : lo;
    fin_result = prod[WIDTH-1:0];
    // The product fits in 32 signed bits only if bits 63..31 are a pure sign extension.
    fin_exc    = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
    if (is_div) begin
      if (div_zero) begin
        fin_result = '0;
        fin_exc    = 1'b1;
      end else begin
        fin_result = quot;
        // A positive quotient of magnitude 2^31 only arises from INT_MIN / -1.
        fin_exc    = (lo == INT_MIN) & ~neg;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= '0;
      hi             <= '0;
      lo             <= '0;
      operand        <= '0;
      neg            <= 1'b0;
      div_zero       <= 1'b0;
      is_div         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;

      case (state)
        MUL, DIV: begin
          hi    <= hi_next;
          lo    <= lo_next;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(ITERS - 1)) state <= DONE;
        end
        DONE: begin
          data_result    <= fin_result;
          data_exception <= fin_exc;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: ;
      endcase

      // A start in any state wins over the transitions above; DONE still publishes.
      if (start) begin
        state    <= ctrl_MULT ? MUL : DIV;
        count    <= '0;
        hi       <= '0;
        lo       <= magnitude(data_operandA);
        operand  <= magnitude(data_operandB);
        neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= (data_operandB == '0);
        is_div   <= ~ctrl_MULT;
        busy     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed vectors with literal expectations
// plus a cycle-level reference model compared against the outputs every cycle.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed arithmetic, returns {exception, result}.
  function automatic logic [32:0] ref_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb, q;
    longint p;
    sa = a;
    sb = b;
    if (is_mul) begin
      p = longint'(sa) * longint'(sb);
      return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
    end
    if (sb == 0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = sa / sb;
    return {1'b0, q};
  endfunction

  // Model: an op started at edge N publishes at edge N+33; a later start replaces it.
  bit          m_pend = 1'b0;
  int          m_due = 0;
  int          edge_n = 0;
  logic [31:0] m_res = '0;
  logic        m_exc = 1'b0;
  logic [31:0] m_pub_res = '0;
  logic        m_pub_exc = 1'b0;
  logic        m_rdy = 1'b0;
  logic        m_busy = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = 1'b0; m_rdy = 1'b0; m_busy = 1'b0;
      m_pub_res = '0; m_pub_exc = 1'b0; edge_n = 0;
    end else begin
      edge_n++;
      m_rdy = 1'b0;
      if (m_pend && edge_n == m_due) begin
        m_pub_res = m_res; m_pub_exc = m_exc;
        m_rdy = 1'b1; m_pend = 1'b0; m_busy = 1'b0;
      end
      if (ctrl_MULT || ctrl_DIV) begin
        {m_exc, m_res} = ref_op(ctrl_MULT, data_operandA, data_operandB);
        m_pend = 1'b1; m_due = edge_n + 33; m_busy = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    check("cyc_rdy",    64'(data_resultRDY), 64'(m_rdy));
    check("cyc_busy",   64'(busy),           64'(m_busy));
    check("cyc_result", 64'(data_result),    64'(m_pub_res));
    check("cyc_exc",    64'(data_exception), 64'(m_pub_exc));
  end

  // Drives a one-cycle start from a negedge; returns at the negedge after the start edge.
  task automatic pulse(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
  endtask

  task automatic run_op(input string name, input bit m, input bit d, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input bit ee);
    int lat;
    lat = -1;
    pulse(m, d, a, b);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        lat = k;
        break;
      end
    end
    check({name, "_lat"}, 64'(lat), 64'd33);
    check({name, "_res"}, 64'(data_result), 64'(er));
    check({name, "_exc"}, 64'(data_exception), 64'(ee));
  endtask

  logic [31:0] specials [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF, 32'h0001_0000};

  function automatic logic [31:0] rnd_operand();
    int v;
    case ($urandom_range(0, 5))
      0:       return specials[$urandom_range(0, 5)];
      1, 2: begin
        v = int'($urandom_range(0, 200)) - 100;
        return v;
      end
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int rdy_cnt;
    int lat;
    logic [31:0] res_at_rdy;
    int w;
    bit m;

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_result", 64'(data_result),    64'd0);
    check("rst_exc",    64'(data_exception), 64'd0);
    check("rst_rdy",    64'(data_resultRDY), 64'd0);
    check("rst_busy",   64'(busy),           64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    check("model_mul", 64'(ref_op(1'b1, 32'd7, 32'hFFFF_FFFA)), {31'd0, 1'b0, 32'hFFFF_FFD6});
    check("model_div", 64'(ref_op(1'b0, 32'hFFFF_FFF9, 32'd2)), {31'd0, 1'b0, 32'hFFFF_FFFD});

    run_op("mul_7_m6",    1, 0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 0);
    run_op("mul_ovf",     1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0,         1);
    run_op("mul_min_1",   1, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 0);
    run_op("mul_min_m1",  1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("mul_m1_m1",   1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h1,         0);
    run_op("div_m7_2",    0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
    run_op("div_min_1",   0, 1, 32'h8000_0000,  32'd1,         32'h8000_0000, 0);
    run_op("div_min_m1",  0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("div_5_0",     0, 1, 32'd5,          32'd0,         32'h0,         1);
    run_op("both_3_4",    1, 1, 32'd3,          32'd4,         32'd12,        0);

    // Abort: DIV 100/7 started ten edges after MULT 3*4.
    pulse(1, 0, 32'd3, 32'd4);
    repeat (9) @(negedge clock);
    pulse(0, 1, 32'd100, 32'd7);
    rdy_cnt = 0; lat = -1; res_at_rdy = '0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        rdy_cnt++;
        if (lat < 0) begin
          lat = k;
          res_at_rdy = data_result;
        end
      end
    end
    check("abort_pulses", 64'(rdy_cnt),    64'd1);
    check("abort_lat",    64'(lat),        64'd33);
    check("abort_res",    64'(res_at_rdy), 64'd14);

    // Asynchronous reset in the middle of an operation.
    pulse(1, 0, 32'd7, 32'hFFFF_FFFA);
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_result", 64'(data_result),    64'd0);
    check("arst_exc",    64'(data_exception), 64'd0);
    check("arst_rdy",    64'(data_resultRDY), 64'd0);
    check("arst_busy",   64'(busy),           64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    check("arst_no_rdy", 64'(rdy_cnt), 64'd0);

    // Start landing on the DONE edge: old result still published, new op runs full latency.
    pulse(1, 0, 32'd7, 32'hFFFF_FFFA);
    repeat (32) @(negedge clock);
    pulse(0, 1, 32'd100, 32'd7);
    check("done_rdy",  64'(data_resultRDY), 64'd1);
    check("done_res",  64'(data_result),    64'hFFFF_FFD6);
    check("done_busy", 64'(busy),           64'd1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        lat = k;
        break;
      end
    end
    check("done_next_lat", 64'(lat),         64'd33);
    check("done_next_res", 64'(data_result), 64'd14);

    // Random operations with gaps straddling the DONE edge (some abort, some chain).
    for (int i = 0; i < 200; i++) begin
      w = $urandom_range(28, 36);
      m = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) pulse(1, 1, rnd_operand(), rnd_operand());
      else pulse(m, !m, rnd_operand(), rnd_operand());
      repeat (w - 1) @(negedge clock);
    end
    repeat (40) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
